// File: rtl/inst_fetch_queue_pkg.sv
// Shared defaults and the fetch-entry layout for the instruction fetch queue.
`default_nettype none

package inst_fetch_queue_pkg;

  localparam int IFQ_DATA_WIDTH = 15;
  localparam int IFQ_ADDR_WIDTH = 8;
  localparam int IFQ_DEPTH      = 4;

  typedef struct packed {
    logic [IFQ_ADDR_WIDTH-1:0] addr;
    logic [IFQ_DATA_WIDTH-1:0] data;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [IFQ_ADDR_WIDTH-1:0] addr,
                                              input logic [IFQ_DATA_WIDTH-1:0] data);
    fetch_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_fifo.sv
// Small synchronous FIFO with flush; head outputs read as zero when empty.
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         head_valid,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign push_ok    = push && !flush;
  assign pop_ok     = pop && head_valid && !flush;

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, hides the ROM's one-cycle read latency and
// buffers {addr, data} entries for a valid/ready consumer.
`default_nettype none

module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH = IFQ_DATA_WIDTH,
  parameter int ADDR_WIDTH = IFQ_ADDR_WIDTH,
  parameter int DEPTH      = IFQ_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_addr,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [DATA_WIDTH-1:0]        rom_data,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [DATA_WIDTH-1:0]        inst_data,
  output logic [ADDR_WIDTH-1:0]        inst_addr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  pending;
  logic [CNT_W:0]        inflight;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  head_valid;
  logic [ENTRY_W-1:0]    head_data;

  // Credit counts registered occupancy plus the read in flight, so a capture
  // can never land on a full queue; a same-cycle pop is deliberately ignored.
  assign inflight = {1'b0, count} + (CNT_W+1)'(pending);
  assign issue    = enable && !redirect_valid && (inflight < (CNT_W+1)'(DEPTH));
  assign push     = pending && !redirect_valid;
  assign pop      = head_valid && inst_ready && !redirect_valid;

  assign rom_addr   = pc;
  assign inst_valid = head_valid && !redirect_valid;
  assign inst_addr  = inst_valid ? head_data[ENTRY_W-1:DATA_WIDTH] : '0;
  assign inst_data  = inst_valid ? head_data[DATA_WIDTH-1:0]      : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= '0;
      pend_addr <= '0;
      pending   <= 1'b0;
    end else if (redirect_valid) begin
      pc      <= redirect_addr;
      pending <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pend_addr <= pc;
        pc        <= pc + ADDR_WIDTH'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  ({pend_addr, rom_data}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (count)
  );

endmodule

`default_nettype wire

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch stage sitting between the instruction ROM and the processor. It owns the program counter, drives the ROM address, absorbs the ROM's one-cycle synchronous read latency, and buffers fetched 15-bit instructions with their addresses in a small queue. The processor consumes instructions through a valid/ready handshake and can redirect fetch (branch/jump), which flushes all buffered and in-flight work.

## Interface
Parameters:
- DATA_WIDTH, 15, instruction width (matches ROM DATA_WIDTH)
- ADDR_WIDTH, 8, instruction address width (matches ROM ADDRESS_WIDTH)
- DEPTH, 4, queue entries; power of two, ≥ 2

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  fetch permitted when high; deasserting stops new issues only
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_addr
- redirect_addr  in  ADDR_WIDTH  new PC, sampled when redirect_valid=1
- rom_addr  out  ADDR_WIDTH  ROM address, driven directly from the PC register
- rom_data  in  DATA_WIDTH  ROM output, valid the cycle after rom_addr was sampled
- inst_valid  out  1  queue head holds a valid instruction
- inst_ready  in  1  processor accepts head when inst_valid && inst_ready
- inst_data  out  DATA_WIDTH  head instruction; 0 when inst_valid=0
- inst_addr  out  ADDR_WIDTH  address of head instruction; 0 when inst_valid=0
- count  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- Reset (reset_n=0, asynchronous): pc=0, rom_addr=0, pending=0, queue empty, count=0, inst_valid=0, inst_data=0, inst_addr=0.
- Issue condition in a cycle: enable && !redirect_valid && (count + pending) < DEPTH. On issue: pending<=1, pend_addr<=pc, pc<=pc+1 (modulo 2^ADDR_WIDTH; 0xFF wraps to 0x00). No issue: pending<=0.
- Capture: when pending=1 in a cycle and no redirect, {pend_addr, rom_data} is written to the queue tail at the end of that cycle.
- Pop: inst_valid && inst_ready && !redirect_valid removes the head. A pop does not free credit for an issue in the same cycle (credit uses registered count only).
- Simultaneous capture and pop: both occur; count unchanged.
- Redirect (highest priority): queue emptied, pending<=0 (in-flight ROM read discarded), pc<=redirect_addr, no issue, no pop. inst_valid forced 0 during the redirect cycle.
- enable low: in-flight read still captured; queue still drains.
- Credit rule guarantees capture never finds the queue full; overflow is impossible by construction and is asserted against in the bench.

## Timing
- Fetch latency: issue in cycle N → ROM samples at end of N → rom_data valid in N+1 → captured end of N+1 → inst_valid in N+2.
- After reset release with enable=1 and inst_ready=1: first instruction (addr 0) presented in cycle 2, then one instruction per cycle, addresses consecutive.
- Redirect in cycle R: first instruction from redirect_addr presented in cycle R+3 (issue R+1).
- Steady-state throughput 1 instruction/cycle with inst_ready held high; occupancy settles at 1.
- inst_valid/inst_data/inst_addr/count derive from registers only (no combinational path from rom_data); inst_valid additionally gated by redirect_valid.

## Structure
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults and the fetch-entry type {addr, data}.
- One sub-module: fetch_fifo — synchronous DEPTH-entry FIFO with flush, push, pop, count, head outputs zeroed when empty. PC, pending tracking, and credit logic live in the top.

## Test plan
- Reset then enable=1, inst_ready=1, ROM word i = 0x100+i → inst_valid first high cycle 2 with addr 0/data 0x100; then addr 1,2,3… one per cycle.
- inst_ready=0 for 10 cycles → count saturates at 4, rom_addr stops advancing at 4, pending=0; release → addrs 0..4 delivered in order, none lost/duplicated.
- Redirect to 0x20 while queue holds 3 entries and a read is pending → next cycle count=0, inst_valid=0; addr 0x20 presented 3 cycles after redirect, stale data never appears.
- Redirect to 0xFE, run 4 instructions → addresses 0xFE, 0xFF, 0x00, 0x01.
- Assert reset_n low mid-stream between clock edges → outputs zero immediately; after release, fetch restarts at addr 0 with cycle-2 latency.
- Random inst_ready and enable toggling over 500 cycles vs. reference model → in-order addr/data match, count ≤ 4, no push-when-full.
